// File: rtl/cmd_seq_pkg.sv
// Shared types and default widths for the command sequencer.
// S_ERR exists only when CMD_SEQ_TIMEOUT_EN is defined.
package cmd_seq_pkg;

  localparam int unsigned CMD_SEQ_DATA_W = 32;
  localparam int unsigned CMD_SEQ_LOOP_W = 8;
  localparam int unsigned CMD_SEQ_TMO_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_ACK      = 3'd3,
    S_NEXT     = 3'd4,
    S_FIN      = 3'd5
`ifdef CMD_SEQ_TIMEOUT_EN
    ,
    S_ERR      = 3'd6
`endif
  } cmd_seq_state_t;

endpackage

// File: rtl/cmd_sequencer_if.sv
// req/rsp handshake between the sequencer (master) and the commit core (slave).
interface cmd_sequencer_if
  import cmd_seq_pkg::*;
#(
  parameter int unsigned DATA_W = CMD_SEQ_DATA_W
);

  logic              req_vaild;
  logic              req_ready;
  logic [DATA_W-1:0] r_in;
  logic              rsp_vaild;
  logic              rsp_ready;

  modport master (
    output req_vaild,
    output r_in,
    output rsp_ready,
    input  req_ready,
    input  rsp_vaild
  );

  modport slave (
    input  req_vaild,
    input  r_in,
    input  rsp_ready,
    output req_ready,
    output rsp_vaild
  );

endinterface

// File: rtl/cmd_seq_mem.sv
// Program store: DEPTH x DATA_W, synchronous write, asynchronous read (distributed RAM).
// Contents are deliberately not reset so a program survives a sequencer reset.
module cmd_seq_mem
  import cmd_seq_pkg::*;
#(
  parameter int unsigned DATA_W = CMD_SEQ_DATA_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: replays a stored program of instruction words into the commit core.
// Define CMD_SEQ_TIMEOUT_EN to build the response timeout and ERR state.
//
// state      | meaning
// S_IDLE     | waiting for start; program loads accepted
// S_ISSUE    | req_vaild high with the current word until req_ready
// S_WAIT_RSP | waiting for rsp_vaild from commit
// S_ACK      | rsp_ready high for one cycle
// S_NEXT     | choose next address, loop restart or finish
// S_FIN      | done pulse, then idle
// S_ERR      | response timeout: error set, done pulse (timeout build only)
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int unsigned DATA_W = CMD_SEQ_DATA_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned LOOP_W = CMD_SEQ_LOOP_W,
  parameter int unsigned TMO_W  = CMD_SEQ_TMO_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [LOOP_W-1:0]     loop_cnt,
  input  logic                  abort,
  cmd_sequencer_if.master       cmd,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     cur_addr
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TMO_W < 2)) begin : g_bad_cfg
    $error("cmd_sequencer: DEPTH must be a power of two >= 2 and TMO_W >= 2");
  end

  cmd_seq_state_t    state_q, state_nxt;
  logic [ADDR_W-1:0] first_q, first_nxt;
  logic [ADDR_W-1:0] last_q, last_nxt;
  logic [ADDR_W-1:0] cur_q, cur_nxt;
  logic [LOOP_W-1:0] loop_q, loop_nxt;
  logic              abort_q;
  logic              done_nxt;
  logic              load_fire;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] rd_word;
  logic              req_q;
  logic              rsp_rdy_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] r_in_q;

`ifdef CMD_SEQ_TIMEOUT_EN
  // Preloaded to all-ones minus one: terminal count at zero ends the
  // (2**TMO_W - 1)th WAIT_RSP cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = ~TMO_W'(1);
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             err_q;
`endif

  assign load_fire = load_en && (state_q == S_IDLE);

  cmd_seq_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (cur_nxt),
    .rd_data (mem_rd)
  );

  // Write-first: a load in the start cycle to the first address is seen by the first command.
  assign rd_word = (load_fire && (load_addr == cur_nxt)) ? load_data : mem_rd;

  always_comb begin
    state_nxt = state_q;
    first_nxt = first_q;
    last_nxt  = last_q;
    cur_nxt   = cur_q;
    loop_nxt  = loop_q;
`ifdef CMD_SEQ_TIMEOUT_EN
    tmo_nxt   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          first_nxt = first_addr;
          last_nxt  = last_addr;
          loop_nxt  = loop_cnt;
          cur_nxt   = first_addr;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd.req_ready) begin
          state_nxt = S_WAIT_RSP;
`ifdef CMD_SEQ_TIMEOUT_EN
          tmo_nxt   = TMO_LOAD;
`endif
        end
      end
      S_WAIT_RSP: begin
        if (cmd.rsp_vaild) begin
          state_nxt = S_ACK;
        end
`ifdef CMD_SEQ_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_nxt = S_ERR;
        end else begin
          tmo_nxt = tmo_q - 1'b1;
        end
`endif
      end
      S_ACK: begin
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (abort_q || abort) begin
          state_nxt = S_FIN;
        end else if (cur_q != last_q) begin
          cur_nxt   = cur_q + 1'b1;
          state_nxt = S_ISSUE;
        end else if (loop_q != '0) begin
          loop_nxt  = loop_q - 1'b1;
          cur_nxt   = first_q;
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
`ifdef CMD_SEQ_TIMEOUT_EN
      S_ERR: begin
        state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    done_nxt = (state_nxt == S_FIN);
`ifdef CMD_SEQ_TIMEOUT_EN
    if (state_nxt == S_ERR) begin
      done_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      first_q   <= '0;
      last_q    <= '0;
      cur_q     <= '0;
      loop_q    <= '0;
      abort_q   <= 1'b0;
      req_q     <= 1'b0;
      rsp_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_in_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      first_q   <= first_nxt;
      last_q    <= last_nxt;
      cur_q     <= cur_nxt;
      loop_q    <= loop_nxt;
      if (state_nxt == S_IDLE) begin
        abort_q <= 1'b0;
      end else if (abort && (state_q != S_IDLE)) begin
        abort_q <= 1'b1;
      end
      // Outputs are registered from the next state so they line up with state_q.
      req_q     <= (state_nxt == S_ISSUE);
      rsp_rdy_q <= (state_nxt == S_ACK);
      busy_q    <= (state_nxt != S_IDLE);
      done_q    <= done_nxt;
      if (state_nxt == S_ISSUE) begin
        r_in_q <= rd_word;
      end
    end
  end

`ifdef CMD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_nxt;
      if ((state_q == S_IDLE) && start) begin
        err_q <= 1'b0;
      end else if (state_nxt == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign cmd.req_vaild = req_q;
  assign cmd.r_in      = r_in_q;
  assign cmd.rsp_ready = rsp_rdy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_addr      = cur_q;

endmodule
